// File: rtl/memory_access_unit.sv
// MEM stage: valid/ready accept from execute, serialized load/store on a word-addressed
// data memory, registered writeback outputs. Define MEM_PERF_CNT_EN for ld/st/stall counters.
module memory_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_iswb,
    input  logic              in_isld,
    input  logic              in_isst,
    input  logic [2:0]        in_rd,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [DATA_W-1:0] in_op2,
    output logic              iswb,
    output logic              isld,
    output logic [2:0]        rd,
    output logic [DATA_W-1:0] ldresult,
    output logic [DATA_W-1:0] aluresult,
`ifdef MEM_PERF_CNT_EN
    output logic [15:0]       ld_count,
    output logic [15:0]       st_count,
    output logic [15:0]       stall_count,
`endif
    output logic              out_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              iswb_q, iswb_d;
    logic              isld_q, isld_d;
    logic [2:0]        rd_q, rd_d;
    logic [DATA_W-1:0] ldresult_q, ldresult_d;
    logic [DATA_W-1:0] aluresult_q, aluresult_d;

    // Instruction captured while the access is in flight.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, alu_lat_q;
    logic [2:0]        rd_lat_q;
    logic              iswb_lat_q, isld_lat_q, isst_lat_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata, cur_alu;
    logic [2:0]        cur_rd;
    logic              cur_iswb, cur_isld, cur_isst;
    logic              in_mem, start_busy, complete, cur_ld, cur_st;

    assign in_ready   = (state_q == IDLE);
    assign in_mem     = in_isld || in_isst;
    assign start_busy = in_ready && in_valid && in_mem && (MEM_LAT > 1);
    assign complete   = in_ready ? (in_valid && (!in_mem || (MEM_LAT == 1)))
                                 : (cnt_q == 4'd1);
    // A simultaneous load+store request behaves as a plain load.
    assign cur_ld = cur_isld;
    assign cur_st = cur_isst && !cur_isld;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cur_addr  = in_aluresult[ADDR_W-1:0];
        cur_wdata = in_op2;
        cur_alu   = in_aluresult;
        cur_rd    = in_rd;
        cur_iswb  = in_iswb;
        cur_isld  = in_isld;
        cur_isst  = in_isst;
        if (state_q == BUSY) begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_alu   = alu_lat_q;
            cur_rd    = rd_lat_q;
            cur_iswb  = iswb_lat_q;
            cur_isld  = isld_lat_q;
            cur_isst  = isst_lat_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = complete;
        iswb_d      = complete && cur_iswb && !cur_st;
        isld_d      = isld_q;
        rd_d        = rd_q;
        ldresult_d  = ldresult_q;
        aluresult_d = aluresult_q;
        if (start_busy) begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
            end
        end
        if (complete) begin
            isld_d      = cur_ld;
            rd_d        = cur_rd;
            aluresult_d = cur_alu;
            if (cur_ld) begin
                ldresult_d = mem[cur_addr];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            iswb_q      <= 1'b0;
            isld_q      <= 1'b0;
            rd_q        <= 3'd0;
            ldresult_q  <= '0;
            aluresult_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            iswb_q      <= iswb_d;
            isld_q      <= isld_d;
            rd_q        <= rd_d;
            ldresult_q  <= ldresult_d;
            aluresult_q <= aluresult_d;
        end
    end

    always_ff @(posedge clk) begin
        if (start_busy) begin
            addr_q     <= in_aluresult[ADDR_W-1:0];
            wdata_q    <= in_op2;
            alu_lat_q  <= in_aluresult;
            rd_lat_q   <= in_rd;
            iswb_lat_q <= in_iswb;
            isld_lat_q <= in_isld;
            isst_lat_q <= in_isst;
        end
    end

    // NOTE: the memory array has no reset; rst only blocks a write that would land on its edge.
    always_ff @(posedge clk) begin
        if (!rst && complete && cur_st) begin
            mem[cur_addr] <= cur_wdata;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [15:0] ld_cnt_q, st_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q    <= 16'd0;
            st_cnt_q    <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (complete && cur_ld) ld_cnt_q <= ld_cnt_q + 16'd1;
            if (complete && cur_st) st_cnt_q <= st_cnt_q + 16'd1;
            if (in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign ld_count    = ld_cnt_q;
    assign st_count    = st_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign iswb      = iswb_q;
    assign isld      = isld_q;
    assign rd        = rd_q;
    assign ldresult  = ldresult_q;
    assign aluresult = aluresult_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: vector table driven through the handshake, scoreboard of
// expected retirements checked on the falling edge, plus reset and latency corner sequences.
module tb_memory_access_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_iswb, in_isld, in_isst;
    logic [2:0]  in_rd, rd;
    logic [15:0] in_aluresult, in_op2, ldresult, aluresult;
    logic        iswb, isld, out_valid;
`ifdef MEM_PERF_CNT_EN
    logic [15:0] ld_count, st_count, stall_count;
`endif

    memory_access_unit #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_iswb(in_iswb), .in_isld(in_isld), .in_isst(in_isst),
        .in_rd(in_rd), .in_aluresult(in_aluresult), .in_op2(in_op2),
        .iswb(iswb), .isld(isld), .rd(rd), .ldresult(ldresult), .aluresult(aluresult),
`ifdef MEM_PERF_CNT_EN
        .ld_count(ld_count), .st_count(st_count), .stall_count(stall_count),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb, ld, st;
        logic [2:0]  rd;
        logic [15:0] alu, op2;
        logic        e_iswb, e_isld;
        logic [15:0] e_ld;
        int          e_stall;
    } vec_t;

    typedef struct {
        logic        iswb, isld;
        logic [2:0]  rd;
        logic [15:0] alu, ld;
        logic        chk;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[11];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Expected retirements come from the stimulus records, never from the DUT.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    timeout_fail("unexpected_out_valid");
                end else begin
                    e = sb_q.pop_front();
                    check("iswb", iswb, e.iswb);
                    check("isld", isld, e.isld);
                    if (e.chk) begin
                        check("rd", rd, e.rd);
                        check("aluresult", aluresult, e.alu);
                        check("ldresult", ldresult, e.ld);
                    end
                end
            end else begin
                check("out_valid_idle", out_valid, 0);
                check("iswb_idle", iswb, 0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one instruction, wait for acceptance, then measure how long in_ready stays low.
    task automatic issue(input logic wb, ld, st, input logic [2:0] r,
                         input logic [15:0] alu, op2, input logic e_wb, e_ld_f,
                         input logic [15:0] e_ld, input int e_stall, input logic hold);
        sb_t e;
        int  guard;
        in_valid = 1'b1; in_iswb = wb; in_isld = ld; in_isst = st;
        in_rd = r; in_aluresult = alu; in_op2 = op2;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) timeout_fail("accept_wait");
        e.iswb = e_wb; e.isld = e_ld_f; e.rd = r; e.alu = alu; e.ld = e_ld;
        e.chk = !(st && !ld);
        sb_q.push_back(e);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b0;
        check("stall_cycles", guard, e_stall);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        repeat (2) @(posedge clk);
        #1 check(name, sb_q.size(), 0);
    endtask

    initial begin
        in_valid = 1'b0; in_iswb = 1'b0; in_isld = 1'b0; in_isst = 1'b0;
        in_rd = 3'd0; in_aluresult = 16'h0; in_op2 = 16'h0;

        //          wb    ld    st    rd    alu        op2        e_wb  e_ld  e_ldres    stall
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd1, 16'hABCD, 16'h0000, 1'b1, 1'b0, 16'h0000, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd3, 16'h5678, 16'h0000, 1'b1, 1'b0, 16'h0000, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0000, LAT-1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd2, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h1234, LAT-1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0105, 16'hBEEF, 1'b0, 1'b0, 16'h0000, LAT-1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd4, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'hBEEF, LAT-1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'd5, 16'h0010, 16'hFFFF, 1'b1, 1'b1, 16'h1234, LAT-1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd6, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h1234, LAT-1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd7, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 16'h1234, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'd0, 16'h00FF, 16'hA5A5, 1'b0, 1'b0, 16'h0000, LAT-1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd1, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'hA5A5, LAT-1};

        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_iswb", iswb, 0);
        check("rst_isld", isld, 0);
        check("rst_rd", rd, 0);
        check("rst_ldresult", ldresult, 0);
        check("rst_aluresult", aluresult, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].wb, vecs[i].ld, vecs[i].st, vecs[i].rd, vecs[i].alu, vecs[i].op2,
                  vecs[i].e_iswb, vecs[i].e_isld, vecs[i].e_ld, vecs[i].e_stall, 1'b0);
        end
        drain("table_drain");

        // Reset lands on the second busy cycle of a store: the store must be dropped.
        issue(1'b0, 1'b0, 1'b1, 3'd0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0, LAT-1, 1'b0);
        drain("preload_drain");
        in_valid = 1'b1; in_isld = 1'b0; in_isst = 1'b1; in_iswb = 1'b0;
        in_rd = 3'd0; in_aluresult = 16'h0020; in_op2 = 16'h5555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_busy", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        repeat (LAT + 1) @(posedge clk);
        #1 check("abort_quiet", out_valid, 0);
        issue(1'b1, 1'b1, 1'b0, 3'd3, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h0000, LAT-1, 1'b0);
        drain("abort_drain");

`ifdef MEM_PERF_CNT_EN
        mon_en = 1'b0;
        do_reset();
        check("perf_rst_ld", ld_count, 0);
        check("perf_rst_stall", stall_count, 0);
        mon_en = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 3'd0, 16'h0030, 16'h1111, 1'b0, 1'b0, 16'h0, LAT-1, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 3'd1, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h1111, LAT-1, 1'b1);
        issue(1'b0, 1'b0, 1'b1, 3'd0, 16'h0031, 16'h2222, 1'b0, 1'b0, 16'h0, LAT-1, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 3'd2, 16'h0031, 16'h0000, 1'b1, 1'b1, 16'h2222, LAT-1, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 3'd4, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h1111, LAT-1, 1'b1);
        drain("perf_drain");
        check("ld_count", ld_count, 3);
        check("st_count", st_count, 2);
        check("stall_count", stall_count, 5 * (LAT - 1));
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
